wire_pattern_gen: RTL and testbench
===================================

Name: wire_pattern_gen

Overview:
- Parametrised board-bring-up pattern generator for the Panologic G2 wire-verification builds.
- Drives NUM_PINS output pins with a selectable pattern: binary count, walking-one, walking-zero or single-pin toggle. Patterns advance at a programmable step rate and can be paused.
- A free-running heartbeat cycles the three status LEDs, so pin continuity to FTDI/expansion headers can be probed with a scope or logic analyser.

Parameters:
- NUM_PINS, 13, number of driven pins (2..32).
- STEP_DIV, 1, SYSCLK cycles per pattern step (>=1); 1 = advance every clock.
- LED_DIV, 25000000, SYSCLK cycles per LED heartbeat increment (>=2).
- SEL_W, 5, width of PIN_SEL (2^SEL_W >= NUM_PINS).

Ports:
- SYSCLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- MODE  in  2  pattern select: 0 count, 1 walking-one, 2 walking-zero, 3 single-pin toggle.
- PIN_SEL  in  SEL_W  pin index toggled in mode 3.
- PAUSE  in  1  1 = hold pattern and step prescaler.
- PINS  out  NUM_PINS  registered pattern output.
- STEP  out  1  one-cycle pulse, coincident with each PINS update caused by a step.
- LEDS  out  3  heartbeat counter: [0] red, [1] blue, [2] green.

Behaviour:
- Reset (RST_N low, asynchronous): PINS=0, STEP=0, LEDS=0, prescaler=0, LED counter=0, mode_q=0, loaded=0. All outputs are registered.
- First edge after reset release (loaded=0): mode_q<=MODE; PINS<=init(MODE); prescaler<=0; loaded<=1; no STEP.
  - init values: count=0, walk1=1, walk0=~1 (all ones except bit0 cleared), toggle=0.
- Mode change (loaded=1, MODE!=mode_q): same as first-edge load. Takes priority over any step in that cycle. STEP=0. PAUSE is ignored for the load.
- Prescaler: counts 0..STEP_DIV-1 while PAUSE=0. A step occurs on the edge where prescaler==STEP_DIV-1, which then wraps to 0. With STEP_DIV=1, a step occurs every cycle.
- PAUSE=1: prescaler and PINS hold. STEP=0. On PAUSE deassertion, counting resumes from the held prescaler value.
- Step actions, registered (PINS and STEP update on the same edge):
  - mode 0: PINS<=PINS+1, modulo 2^NUM_PINS; wraps all-ones -> 0.
  - mode 1: rotate left by 1; bit NUM_PINS-1 -> bit0.
  - mode 2: rotate left by 1 (the single zero walks).
  - mode 3: if PIN_SEL<NUM_PINS, PINS<=PINS ^ (1<<PIN_SEL), other bits forced 0. If PIN_SEL>=NUM_PINS, PINS<=0.
- PIN_SEL change in mode 3 is not a mode change. At the next step the new pin toggles from its current value (0) and the old pin clears.
- LED counter: independent of PAUSE/MODE; counts 0..LED_DIV-1. On wrap, LEDS<=LEDS+1 (3-bit, 7 -> 0). Exactly LED_DIV cycles per increment.
- Async reset mid-pattern: immediate return to reset values; reload on the first edge after release.
- Static checks (elaboration-time): NUM_PINS<2 or >32, STEP_DIV<1, LED_DIV<2, or 2^SEL_W<NUM_PINS is an elaboration error.

Test Plan:
- NUM_PINS=4, STEP_DIV=1, MODE=0 from reset -> 1st edge PINS=0 (load), then 1,2,...,15,0. STEP high every cycle after the load.
- NUM_PINS=4, STEP_DIV=3, MODE=1 -> load PINS=0001. Then every 3rd cycle: 0010, 0100, 1000, 0001. STEP pulses 1 cycle in 3.
- MODE=2, NUM_PINS=4 -> load 1110, then 1101, 1011, 0111, 1110. Switch MODE to 0 mid-sequence -> next edge PINS=0, STEP=0, prescaler restarts.
- MODE=3, PIN_SEL=2, STEP_DIV=2 -> PINS alternates 0000/0100 every 2 cycles. PIN_SEL=9 with NUM_PINS=4 -> PINS=0000 at next step.
- PAUSE high for 10 cycles mid-count at PINS=5 -> PINS stays 5, no STEP. On release, counting resumes from the held prescaler value. LEDS unaffected.
- LED_DIV=4 -> LEDS increments every 4 cycles, wraps 7->0 after 32 cycles. Assert RST_N low asynchronously mid-run -> all outputs 0 without a clock edge.

Source files
------------

// File: rtl/wire_pattern_gen.sv
// -----------------------------------------------------------------------------
// wire_pattern_gen
//
// Board-bring-up pattern generator. Drives NUM_PINS pins with a selectable
// pattern (binary count, walking-one, walking-zero, single-pin toggle) that
// advances once every STEP_DIV clocks unless paused. A free-running 3-bit
// heartbeat on the status LEDs advances once every LED_DIV clocks.
//
// Ports:
//   SYSCLK   in   1         system clock
//   RST_N    in   1         asynchronous active-low reset
//   MODE     in   2         0 count, 1 walking-one, 2 walking-zero, 3 toggle
//   PIN_SEL  in   SEL_W     pin index toggled in mode 3
//   PAUSE    in   1         holds pattern and step prescaler
//   PINS     out  NUM_PINS  registered pattern output
//   STEP     out  1         one-cycle pulse with each stepped PINS update
//   LEDS     out  3         heartbeat counter: [0] red, [1] blue, [2] green
// -----------------------------------------------------------------------------
module wire_pattern_gen #(
    parameter int unsigned NUM_PINS = 13,
    parameter int unsigned STEP_DIV = 1,
    parameter int unsigned LED_DIV  = 25000000,
    parameter int unsigned SEL_W    = 5
) (
    input  logic                SYSCLK,
    input  logic                RST_N,
    input  logic [1:0]          MODE,
    input  logic [SEL_W-1:0]    PIN_SEL,
    input  logic                PAUSE,
    output logic [NUM_PINS-1:0] PINS,
    output logic                STEP,
    output logic [2:0]          LEDS
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    if (NUM_PINS < 2 || NUM_PINS > 32) begin : gen_bad_num_pins
        $error("wire_pattern_gen: NUM_PINS must be in 2..32");
    end
    if (STEP_DIV < 1) begin : gen_bad_step_div
        $error("wire_pattern_gen: STEP_DIV must be >= 1");
    end
    if (LED_DIV < 2) begin : gen_bad_led_div
        $error("wire_pattern_gen: LED_DIV must be >= 2");
    end
    if (SEL_W < 1 || SEL_W > 31 || (64'd1 << SEL_W) < 64'(NUM_PINS)) begin : gen_bad_sel_w
        $error("wire_pattern_gen: 2**SEL_W must cover NUM_PINS");
    end

    // -------------------------------------------------------------------------
    // Types and constants
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ModeCount  = 2'd0,
        ModeWalk1  = 2'd1,
        ModeWalk0  = 2'd2,
        ModeToggle = 2'd3
    } mode_e;

    localparam int unsigned PrescW  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned LedCntW = $clog2(LED_DIV);

    localparam logic [PrescW-1:0]   PrescLast  = PrescW'(STEP_DIV - 1);
    localparam logic [LedCntW-1:0]  LedCntLast = LedCntW'(LED_DIV - 1);
    localparam logic [NUM_PINS-1:0] PinsOne    = {{(NUM_PINS-1){1'b0}}, 1'b1};

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    mode_e               mode_q;
    logic                loaded_q;
    logic [PrescW-1:0]   presc_q,   presc_d;
    logic [NUM_PINS-1:0] pins_q,    pins_d;
    logic                step_q,    step_d;
    logic [LedCntW-1:0]  led_cnt_q, led_cnt_d;
    logic [2:0]          leds_q,    leds_d;

    mode_e               mode_in;
    logic                do_load;
    logic                sel_valid;
    logic [NUM_PINS-1:0] sel_mask;
    logic [NUM_PINS-1:0] init_pins;
    logic [NUM_PINS-1:0] stepped_pins;

    assign mode_in   = mode_e'(MODE);
    // A load happens on the first edge after reset and whenever MODE changes;
    // it outranks both PAUSE and any step due in the same cycle.
    assign do_load   = !loaded_q || (mode_in != mode_q);
    assign sel_valid = 32'(PIN_SEL) < NUM_PINS;
    assign sel_mask  = PinsOne << PIN_SEL;

    // -------------------------------------------------------------------------
    // Pattern values
    // -------------------------------------------------------------------------
    always_comb begin
        init_pins = '0;
        unique case (mode_in)
            ModeCount:  init_pins = '0;
            ModeWalk1:  init_pins = PinsOne;
            ModeWalk0:  init_pins = ~PinsOne;
            ModeToggle: init_pins = '0;
            default:    init_pins = '0;
        endcase
    end

    always_comb begin
        stepped_pins = pins_q;
        unique case (mode_q)
            ModeCount: stepped_pins = pins_q + PinsOne;
            ModeWalk1,
            ModeWalk0: stepped_pins = {pins_q[NUM_PINS-2:0], pins_q[NUM_PINS-1]};
            ModeToggle: begin
                // Only the selected pin survives, inverted; a stale pin from a
                // previous PIN_SEL is cleared. Out-of-range selects clear all.
                if (sel_valid) begin
                    stepped_pins = (pins_q & sel_mask) ^ sel_mask;
                end else begin
                    stepped_pins = '0;
                end
            end
            default: stepped_pins = pins_q;
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state: pattern and prescaler
    // -------------------------------------------------------------------------
    always_comb begin
        presc_d = presc_q;
        pins_d  = pins_q;
        step_d  = 1'b0;
        if (do_load) begin
            presc_d = '0;
            pins_d  = init_pins;
        end else if (!PAUSE) begin
            if (presc_q == PrescLast) begin
                presc_d = '0;
                pins_d  = stepped_pins;
                step_d  = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state: heartbeat, independent of MODE and PAUSE
    // -------------------------------------------------------------------------
    always_comb begin
        led_cnt_d = led_cnt_q + 1'b1;
        leds_d    = leds_q;
        if (led_cnt_q == LedCntLast) begin
            led_cnt_d = '0;
            leds_d    = leds_q + 3'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge SYSCLK or negedge RST_N) begin
        if (!RST_N) begin
            mode_q    <= ModeCount;
            loaded_q  <= 1'b0;
            presc_q   <= '0;
            pins_q    <= '0;
            step_q    <= 1'b0;
            led_cnt_q <= '0;
            leds_q    <= '0;
        end else begin
            mode_q    <= mode_in;
            loaded_q  <= 1'b1;
            presc_q   <= presc_d;
            pins_q    <= pins_d;
            step_q    <= step_d;
            led_cnt_q <= led_cnt_d;
            leds_q    <= leds_d;
        end
    end

    assign PINS = pins_q;
    assign STEP = step_q;
    assign LEDS = leds_q;

endmodule

// File: tb/tb_wire_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_wire_pattern_gen
//
// Three 4-pin instances with STEP_DIV = 1, 2 and 3 share one stimulus stream.
// A behavioural model tracks, per instance, the number of unpaused cycles since
// the last load and derives the expected pattern from it arithmetically; the
// heartbeat is derived from the cycle count since reset release.
// -----------------------------------------------------------------------------
module tb_wire_pattern_gen;

    localparam int NP      = 4;
    localparam int LED_DIV = 4;
    localparam int N_DUT   = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] mode  = 2'd0;
    logic [3:0] sel   = 4'd0;
    logic       pause = 1'b0;

    logic [NP-1:0] dut_pins [N_DUT];
    logic          dut_step [N_DUT];
    logic [2:0]    dut_leds [N_DUT];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wire_pattern_gen #(.NUM_PINS(NP), .STEP_DIV(1), .LED_DIV(LED_DIV), .SEL_W(4)) u_div1 (
        .SYSCLK (clk),
        .RST_N  (rst_n),
        .MODE   (mode),
        .PIN_SEL(sel),
        .PAUSE  (pause),
        .PINS   (dut_pins[0]),
        .STEP   (dut_step[0]),
        .LEDS   (dut_leds[0])
    );

    wire_pattern_gen #(.NUM_PINS(NP), .STEP_DIV(2), .LED_DIV(LED_DIV), .SEL_W(4)) u_div2 (
        .SYSCLK (clk),
        .RST_N  (rst_n),
        .MODE   (mode),
        .PIN_SEL(sel),
        .PAUSE  (pause),
        .PINS   (dut_pins[1]),
        .STEP   (dut_step[1]),
        .LEDS   (dut_leds[1])
    );

    wire_pattern_gen #(.NUM_PINS(NP), .STEP_DIV(3), .LED_DIV(LED_DIV), .SEL_W(4)) u_div3 (
        .SYSCLK (clk),
        .RST_N  (rst_n),
        .MODE   (mode),
        .PIN_SEL(sel),
        .PAUSE  (pause),
        .PINS   (dut_pins[2]),
        .STEP   (dut_step[2]),
        .LEDS   (dut_leds[2])
    );

    // -------------------------------------------------------------------------
    // Behavioural model
    // -------------------------------------------------------------------------
    int m_mode   = 0;
    int m_loaded = 0;
    int m_cycles = 0;
    int m_run  [N_DUT] = '{0, 0, 0};
    int m_tog  [N_DUT] = '{0, 0, 0};
    int m_step [N_DUT] = '{0, 0, 0};

    function automatic int div_of(input int k);
        return k + 1;
    endfunction

    // Expected PINS from the step count since the last load.
    function automatic int exp_pins(input int k);
        int s;
        s = m_run[k] / div_of(k);
        case (m_mode)
            0:       return s % 16;
            1:       return 1 << (s % NP);
            2:       return 15 ^ (1 << (s % NP));
            default: return m_tog[k];
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int r;
        int t;
        if (!rst_n) begin
            m_mode   <= 0;
            m_loaded <= 0;
            m_cycles <= 0;
            for (int k = 0; k < N_DUT; k++) begin
                m_run[k]  <= 0;
                m_tog[k]  <= 0;
                m_step[k] <= 0;
            end
        end else begin
            m_cycles <= m_cycles + 1;
            m_loaded <= 1;
            m_mode   <= int'(mode);
            for (int k = 0; k < N_DUT; k++) begin
                if (m_loaded == 0 || int'(mode) != m_mode) begin
                    m_run[k]  <= 0;
                    m_tog[k]  <= 0;
                    m_step[k] <= 0;
                end else if (pause) begin
                    m_step[k] <= 0;
                end else begin
                    r = m_run[k] + 1;
                    m_run[k] <= r;
                    if (r % div_of(k) == 0) begin
                        m_step[k] <= 1;
                        if (int'(sel) < NP) begin
                            t = ((m_tog[k] >> sel) & 1) != 0 ? 0 : (1 << sel);
                        end else begin
                            t = 0;
                        end
                        m_tog[k] <= t;
                    end else begin
                        m_step[k] <= 0;
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Checking
    // -------------------------------------------------------------------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < N_DUT; k++) begin
            chk($sformatf("model pins div%0d", div_of(k)), int'(dut_pins[k]), exp_pins(k));
            chk($sformatf("model step div%0d", div_of(k)), int'(dut_step[k]), m_step[k]);
            chk($sformatf("model leds div%0d", div_of(k)), int'(dut_leds[k]),
                (m_cycles / LED_DIV) % 8);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // -------------------------------------------------------------------------
    // Directed stimulus with hand-computed pins
    // -------------------------------------------------------------------------
    initial begin
        #1 rst_n = 1'b0;
        #6;
        for (int k = 0; k < N_DUT; k++) begin
            chk("reset pins", int'(dut_pins[k]), 0);
            chk("reset step", int'(dut_step[k]), 0);
            chk("reset leds", int'(dut_leds[k]), 0);
        end
        #5 rst_n = 1'b1;                      // release at t=12, between edges

        // Binary count
        tick(1);
        chk("load count pins", int'(dut_pins[0]), 0);
        chk("load count step", int'(dut_step[0]), 0);
        tick(1);
        chk("count first step pins", int'(dut_pins[0]), 1);
        chk("count first step strobe", int'(dut_step[0]), 1);
        tick(15);
        chk("count wrap pins", int'(dut_pins[0]), 0);
        chk("div3 count pins", int'(dut_pins[2]), 5);
        chk("leds after 17 edges", int'(dut_leds[0]), 4);

        // Pause with div3 at 5, prescaler mid-count
        pause = 1'b1;
        tick(10);
        chk("pause hold pins", int'(dut_pins[2]), 5);
        chk("pause step low", int'(dut_step[2]), 0);
        chk("leds during pause", int'(dut_leds[2]), 6);
        pause = 1'b0;
        tick(1);
        chk("resume no step yet", int'(dut_pins[2]), 5);
        tick(1);
        chk("resume step pins", int'(dut_pins[2]), 6);
        chk("resume step strobe", int'(dut_step[2]), 1);
        chk("div1 after resume", int'(dut_pins[0]), 2);

        // Walking one
        mode = 2'd1;
        tick(1);
        chk("load walk1 pins", int'(dut_pins[2]), 1);
        chk("load walk1 step", int'(dut_step[0]), 0);
        tick(3);
        chk("walk1 div3 pins", int'(dut_pins[2]), 2);
        chk("walk1 div1 pins", int'(dut_pins[0]), 8);
        tick(8);

        // Walking zero, then change to count mid-sequence
        mode = 2'd2;
        tick(1);
        chk("load walk0 pins", int'(dut_pins[0]), 14);
        tick(1);
        chk("walk0 step1", int'(dut_pins[0]), 13);
        tick(1);
        chk("walk0 step2", int'(dut_pins[0]), 11);
        mode = 2'd0;
        tick(1);
        chk("mode change pins", int'(dut_pins[0]), 0);
        chk("mode change step", int'(dut_step[0]), 0);
        tick(4);

        // Single-pin toggle
        mode = 2'd3;
        sel  = 4'd2;
        tick(1);
        chk("load toggle pins", int'(dut_pins[1]), 0);
        tick(2);
        chk("toggle div2 on", int'(dut_pins[1]), 4);
        tick(2);
        chk("toggle div2 off", int'(dut_pins[1]), 0);
        tick(1);
        chk("toggle div1 on", int'(dut_pins[0]), 4);
        sel = 4'd1;
        tick(1);
        chk("toggle new sel", int'(dut_pins[0]), 2);
        sel = 4'd9;
        tick(1);
        chk("toggle out of range", int'(dut_pins[0]), 0);
        tick(4);

        // Asynchronous reset mid-cycle
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < N_DUT; k++) begin
            chk("async reset pins", int'(dut_pins[k]), 0);
            chk("async reset step", int'(dut_step[k]), 0);
            chk("async reset leds", int'(dut_leds[k]), 0);
        end
        tick(2);
        #2 rst_n = 1'b1;
        tick(1);
        chk("reload after reset", int'(dut_pins[0]), 0);
        mode = 2'd1;
        tick(6);

        // Long run for heartbeat wrap 7 -> 0
        mode = 2'd0;
        tick(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
